node_endpoint: RTL and testbench

- NoC endpoint (node-side) that forms the other end of the router's per-port byte-serial link.
- Accepts whole 32-bit packets from the local client and serializes each to the router as 4 bytes, MSB first.
- Deserializes 4-byte transfers from the router back into 32-bit packets and buffers them for the client.
- One instance sits on each router port. The router is unchanged.

---
 rtl/node_endpoint.sv | 261 ++++++++++++++++++++++++++
 tb/tb_node_endpoint.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_endpoint.sv
// node_endpoint: node-side end of a router port's byte-serial link.
//
// Client side:
//   pkt_in / pkt_in_valid / pkt_in_ready   32-bit packets into the TX FIFO
//   pkt_out / pkt_out_valid / pkt_out_ready 32-bit packets out of the RX FIFO
// Router side:
//   put_outbound / payload_outbound / free_outbound  4 bytes per packet, MSB first
//   put_inbound / payload_inbound / free_inbound     4 bytes per packet, MSB first
// Status:
//   rx_error   one-cycle pulse on a truncated inbound packet or an overflow drop
//   misroute   one-cycle pulse when a stored packet's dest differs from NODEID
//   tx_count   packets fully sent (wraps)
//   rx_count   packets stored in the RX FIFO (wraps)
module node_endpoint #(
   parameter logic [3:0]  NODEID   = 4'd0,
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] pkt_in,
   input  logic        pkt_in_valid,
   output logic        pkt_in_ready,
   input  logic        free_outbound,
   output logic        put_outbound,
   output logic [7:0]  payload_outbound,
   input  logic        put_inbound,
   input  logic [7:0]  payload_inbound,
   output logic        free_inbound,
   output logic [31:0] pkt_out,
   output logic        pkt_out_valid,
   input  logic        pkt_out_ready,
   output logic        rx_error,
   output logic        misroute,
   output logic [15:0] tx_count,
   output logic [15:0] rx_count
);

   localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
   localparam int unsigned TxCntW = $clog2(TX_DEPTH + 1);
   localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
   localparam int unsigned RxCntW = $clog2(RX_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StSend, StGap} tx_state_e;

   // ---------------------------------------------------------------- TX FIFO
   logic [31:0]       tx_mem_q [TX_DEPTH];
   logic [TxPtrW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
   logic              tx_push, tx_pop;
   logic [31:0]       tx_head;

   assign pkt_in_ready = (tx_cnt_q != TxCntW'(TX_DEPTH));
   assign tx_push      = pkt_in_valid && pkt_in_ready;
   assign tx_head      = tx_mem_q[tx_rd_q];

   always_comb begin
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push) begin
         tx_wr_d = (tx_wr_q == TxPtrW'(TX_DEPTH - 1)) ? '0 : tx_wr_q + TxPtrW'(1);
      end
      if (tx_pop) begin
         tx_rd_d = (tx_rd_q == TxPtrW'(TX_DEPTH - 1)) ? '0 : tx_rd_q + TxPtrW'(1);
      end
      if (tx_push && !tx_pop) begin
         tx_cnt_d = tx_cnt_q + TxCntW'(1);
      end else if (!tx_push && tx_pop) begin
         tx_cnt_d = tx_cnt_q - TxCntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (tx_push) begin
         tx_mem_q[tx_wr_q] <= pkt_in;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   tx_state_e   tx_state_q, tx_state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic        put_q, put_d;
   logic [7:0]  payload_q, payload_d;
   logic [15:0] tx_count_q, tx_count_d;

   always_comb begin
      tx_state_d = tx_state_q;
      byte_cnt_d = byte_cnt_q;
      put_d      = 1'b0;
      payload_d  = 8'h00;
      tx_pop     = 1'b0;
      tx_count_d = tx_count_q;
      unique case (tx_state_q)
         StIdle: begin
            if ((tx_cnt_q != '0) && free_outbound) begin
               tx_state_d = StSend;
               byte_cnt_d = 2'd0;
               put_d      = 1'b1;
               payload_d  = tx_head[31:24];
            end
         end
         StSend: begin
            // free_outbound is not looked at here: a started packet always completes.
            if (byte_cnt_q == 2'd3) begin
               tx_state_d = StGap;
               byte_cnt_d = 2'd0;
               tx_pop     = 1'b1;
               tx_count_d = tx_count_q + 16'd1;
            end else begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               put_d      = 1'b1;
               case (byte_cnt_q)
                  2'd0:    payload_d = tx_head[23:16];
                  2'd1:    payload_d = tx_head[15:8];
                  default: payload_d = tx_head[7:0];
               endcase
            end
         end
         StGap: begin
            // One quiet cycle so the router drops its free before we look again.
            tx_state_d = StIdle;
         end
         default: begin
            tx_state_d = StIdle;
         end
      endcase
   end

   assign put_outbound     = put_q;
   assign payload_outbound = payload_q;
   assign tx_count         = tx_count_q;

   // ---------------------------------------------------------------- RX FIFO + assembler
   logic [31:0]       rx_mem_q [RX_DEPTH];
   logic [RxPtrW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
   logic              rx_push, rx_pop;
   logic [31:0]       rx_word;

   logic              asm_q, asm_d;
   logic [1:0]        rx_bcnt_q, rx_bcnt_d;
   logic [23:0]       rx_shift_q, rx_shift_d;
   logic              rx_error_q, rx_error_d;
   logic              misroute_q, misroute_d;
   logic [15:0]       rx_count_q, rx_count_d;
   logic              free_q, free_d;

   assign rx_pop  = pkt_out_ready && (rx_cnt_q != '0);
   assign rx_word = {rx_shift_q, payload_inbound};

   always_comb begin
      asm_d      = asm_q;
      rx_bcnt_d  = rx_bcnt_q;
      rx_shift_d = rx_shift_q;
      rx_error_d = 1'b0;
      misroute_d = 1'b0;
      rx_push    = 1'b0;
      rx_count_d = rx_count_q;
      if (put_inbound) begin
         // Older bytes fall off the top, so after three shifts the register holds bytes 0..2.
         rx_shift_d = {rx_shift_q[15:0], payload_inbound};
         if (!asm_q) begin
            asm_d     = 1'b1;
            rx_bcnt_d = 2'd1;
         end else if (rx_bcnt_q != 2'd3) begin
            rx_bcnt_d = rx_bcnt_q + 2'd1;
         end else begin
            asm_d     = 1'b0;
            rx_bcnt_d = 2'd0;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            if ((rx_cnt_q != RxCntW'(RX_DEPTH)) || rx_pop) begin
               rx_push    = 1'b1;
               rx_count_d = rx_count_q + 16'd1;
               misroute_d = (rx_word[27:24] != NODEID);
            end else begin
               rx_error_d = 1'b1;
            end
         end
      end else if (asm_q) begin
         asm_d      = 1'b0;
         rx_bcnt_d  = 2'd0;
         rx_error_d = 1'b1;
      end
   end

   always_comb begin
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_wr_d = (rx_wr_q == RxPtrW'(RX_DEPTH - 1)) ? '0 : rx_wr_q + RxPtrW'(1);
      end
      if (rx_pop) begin
         rx_rd_d = (rx_rd_q == RxPtrW'(RX_DEPTH - 1)) ? '0 : rx_rd_q + RxPtrW'(1);
      end
      if (rx_push && !rx_pop) begin
         rx_cnt_d = rx_cnt_q + RxCntW'(1);
      end else if (!rx_push && rx_pop) begin
         rx_cnt_d = rx_cnt_q - RxCntW'(1);
      end
      free_d = !asm_d && !put_inbound && (rx_cnt_d != RxCntW'(RX_DEPTH));
   end

   always_ff @(posedge clock) begin
      if (rx_push) begin
         rx_mem_q[rx_wr_q] <= rx_word;
      end
   end

   assign pkt_out       = rx_mem_q[rx_rd_q];
   assign pkt_out_valid = (rx_cnt_q != '0);
   assign free_inbound  = free_q;
   assign rx_error      = rx_error_q;
   assign misroute      = misroute_q;
   assign rx_count      = rx_count_q;

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_cnt_q   <= '0;
         tx_state_q <= StIdle;
         byte_cnt_q <= 2'd0;
         put_q      <= 1'b0;
         payload_q  <= 8'h00;
         tx_count_q <= 16'd0;
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rx_cnt_q   <= '0;
         asm_q      <= 1'b0;
         rx_bcnt_q  <= 2'd0;
         rx_shift_q <= 24'd0;
         rx_error_q <= 1'b0;
         misroute_q <= 1'b0;
         rx_count_q <= 16'd0;
         free_q     <= 1'b1;
      end else begin
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_state_q <= tx_state_d;
         byte_cnt_q <= byte_cnt_d;
         put_q      <= put_d;
         payload_q  <= payload_d;
         tx_count_q <= tx_count_d;
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         rx_cnt_q   <= rx_cnt_d;
         asm_q      <= asm_d;
         rx_bcnt_q  <= rx_bcnt_d;
         rx_shift_q <= rx_shift_d;
         rx_error_q <= rx_error_d;
         misroute_q <= misroute_d;
         rx_count_q <= rx_count_d;
         free_q     <= free_d;
      end
   end

endmodule

// File: tb/tb_node_endpoint.sv
// Directed bench for node_endpoint (NODEID=3, both FIFOs depth 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_node_endpoint;

   logic        clock;
   logic        reset_n;
   logic [31:0] pkt_in;
   logic        pkt_in_valid;
   logic        pkt_in_ready;
   logic        free_outbound;
   logic        put_outbound;
   logic [7:0]  payload_outbound;
   logic        put_inbound;
   logic [7:0]  payload_inbound;
   logic        free_inbound;
   logic [31:0] pkt_out;
   logic        pkt_out_valid;
   logic        pkt_out_ready;
   logic        rx_error;
   logic        misroute;
   logic [15:0] tx_count;
   logic [15:0] rx_count;

   int n_checks;
   int n_fail;

   logic [31:0] tx_vec [4];
   logic [31:0] rx_vec [5];
   logic [31:0] w;

   node_endpoint #(
      .NODEID   (4'd3),
      .TX_DEPTH (4),
      .RX_DEPTH (4)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .pkt_in           (pkt_in),
      .pkt_in_valid     (pkt_in_valid),
      .pkt_in_ready     (pkt_in_ready),
      .free_outbound    (free_outbound),
      .put_outbound     (put_outbound),
      .payload_outbound (payload_outbound),
      .put_inbound      (put_inbound),
      .payload_inbound  (payload_inbound),
      .free_inbound     (free_inbound),
      .pkt_out          (pkt_out),
      .pkt_out_valid    (pkt_out_valid),
      .pkt_out_ready    (pkt_out_ready),
      .rx_error         (rx_error),
      .misroute         (misroute),
      .tx_count         (tx_count),
      .rx_count         (rx_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      pkt_in          = 32'h0;
      pkt_in_valid    = 1'b0;
      free_outbound   = 1'b0;
      put_inbound     = 1'b0;
      payload_inbound = 8'h00;
      pkt_out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Drives the four bytes on consecutive cycles, then drops put.
   task automatic deliver(input logic [31:0] word);
      for (int b = 0; b < 4; b++) begin
         put_inbound     = 1'b1;
         payload_inbound = 8'(word >> (24 - 8 * b));
         tick();
      end
      put_inbound     = 1'b0;
      payload_inbound = 8'h00;
   endtask

   task automatic expect_tx_word(input string tag, input logic [31:0] word);
      for (int b = 0; b < 4; b++) begin
         check_eq({tag, "_put"}, 32'(put_outbound), 32'd1);
         check_eq({tag, "_byte"}, 32'(payload_outbound), 32'(8'(word >> (24 - 8 * b))));
         tick();
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      tx_vec[0] = 32'h41C0FFEE;
      tx_vec[1] = 32'h52123456;
      tx_vec[2] = 32'h63ABCDEF;
      tx_vec[3] = 32'h74000001;
      rx_vec[0] = 32'h03000001;
      rx_vec[1] = 32'h03000002;
      rx_vec[2] = 32'h03000003;
      rx_vec[3] = 32'h03000004;
      rx_vec[4] = 32'h03000005;

      // ---------------- reset values
      do_reset();
      check_eq("rst_in_ready", 32'(pkt_in_ready), 32'd1);
      check_eq("rst_put", 32'(put_outbound), 32'd0);
      check_eq("rst_payload", 32'(payload_outbound), 32'd0);
      check_eq("rst_free_in", 32'(free_inbound), 32'd1);
      check_eq("rst_out_valid", 32'(pkt_out_valid), 32'd0);
      check_eq("rst_rx_error", 32'(rx_error), 32'd0);
      check_eq("rst_misroute", 32'(misroute), 32'd0);
      check_eq("rst_tx_count", 32'(tx_count), 32'd0);
      check_eq("rst_rx_count", 32'(rx_count), 32'd0);

      // ---------------- TX basic
      pkt_in        = 32'h35A1B2C3;
      pkt_in_valid  = 1'b1;
      free_outbound = 1'b1;
      tick();
      check_eq("txb_lat_put", 32'(put_outbound), 32'd0);
      pkt_in_valid = 1'b0;
      tick();
      expect_tx_word("txb", 32'h35A1B2C3);
      check_eq("txb_gap_put", 32'(put_outbound), 32'd0);
      check_eq("txb_tx_count", 32'(tx_count), 32'd1);
      tick();
      check_eq("txb_idle_put", 32'(put_outbound), 32'd0);

      // ---------------- TX backpressure
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pkt_in       = tx_vec[i];
         pkt_in_valid = 1'b1;
         tick();
      end
      check_eq("txbp_full_ready", 32'(pkt_in_ready), 32'd0);
      pkt_in = 32'hDEADBEEF;
      tick();
      pkt_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("txbp_hold_put", 32'(put_outbound), 32'd0);
         tick();
      end
      free_outbound = 1'b1;
      tick();
      free_outbound = 1'b0;
      expect_tx_word("txbp_p0", tx_vec[0]);
      check_eq("txbp_gap_put", 32'(put_outbound), 32'd0);
      check_eq("txbp_tx_count", 32'(tx_count), 32'd1);
      check_eq("txbp_ready_after", 32'(pkt_in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("txbp_wait_put", 32'(put_outbound), 32'd0);
      end
      free_outbound = 1'b1;
      tick();
      free_outbound = 1'b0;
      expect_tx_word("txbp_p1", tx_vec[1]);
      check_eq("txbp_tx_count2", 32'(tx_count), 32'd2);

      // ---------------- RX basic
      do_reset();
      put_inbound     = 1'b1;
      payload_inbound = 8'h03;
      tick();
      check_eq("rxb_free_b0", 32'(free_inbound), 32'd0);
      payload_inbound = 8'h11;
      tick();
      payload_inbound = 8'h22;
      tick();
      check_eq("rxb_free_b2", 32'(free_inbound), 32'd0);
      payload_inbound = 8'h33;
      tick();
      check_eq("rxb_valid", 32'(pkt_out_valid), 32'd1);
      check_eq("rxb_pkt", pkt_out, 32'h03112233);
      check_eq("rxb_misroute", 32'(misroute), 32'd0);
      check_eq("rxb_rx_error", 32'(rx_error), 32'd0);
      check_eq("rxb_rx_count", 32'(rx_count), 32'd1);
      check_eq("rxb_free_store", 32'(free_inbound), 32'd0);
      put_inbound     = 1'b0;
      payload_inbound = 8'h00;
      tick();
      check_eq("rxb_free_after", 32'(free_inbound), 32'd1);
      check_eq("rxb_pkt_stable", pkt_out, 32'h03112233);

      // ---------------- RX misroute
      deliver(32'h04AABBCC);
      check_eq("rxm_misroute", 32'(misroute), 32'd1);
      check_eq("rxm_rx_count", 32'(rx_count), 32'd2);
      check_eq("rxm_head", pkt_out, 32'h03112233);
      tick();
      check_eq("rxm_pulse_end", 32'(misroute), 32'd0);
      pkt_out_ready = 1'b1;
      tick();
      pkt_out_ready = 1'b0;
      check_eq("rxm_stored", pkt_out, 32'h04AABBCC);

      // ---------------- RX truncate
      put_inbound     = 1'b1;
      payload_inbound = 8'hAA;
      tick();
      payload_inbound = 8'hBB;
      tick();
      put_inbound     = 1'b0;
      payload_inbound = 8'h00;
      tick();
      check_eq("rxt_error", 32'(rx_error), 32'd1);
      check_eq("rxt_rx_count", 32'(rx_count), 32'd2);
      tick();
      check_eq("rxt_pulse_end", 32'(rx_error), 32'd0);
      deliver(32'h03445566);
      check_eq("rxt_resync_count", 32'(rx_count), 32'd3);
      check_eq("rxt_resync_err", 32'(rx_error), 32'd0);
      tick();
      pkt_out_ready = 1'b1;
      tick();
      pkt_out_ready = 1'b0;
      check_eq("rxt_resync_pkt", pkt_out, 32'h03445566);

      // ---------------- RX overflow
      do_reset();
      for (int i = 0; i < 4; i++) begin
         deliver(rx_vec[i]);
         tick();
      end
      check_eq("rxo_free_full", 32'(free_inbound), 32'd0);
      check_eq("rxo_rx_count", 32'(rx_count), 32'd4);
      deliver(32'h03DEADBE);
      check_eq("rxo_drop_error", 32'(rx_error), 32'd1);
      check_eq("rxo_drop_count", 32'(rx_count), 32'd4);
      check_eq("rxo_drop_misroute", 32'(misroute), 32'd0);
      tick();
      check_eq("rxo_free_still", 32'(free_inbound), 32'd0);
      pkt_out_ready = 1'b1;
      tick();
      pkt_out_ready = 1'b0;
      check_eq("rxo_free_pop", 32'(free_inbound), 32'd1);
      check_eq("rxo_head_pop", pkt_out, rx_vec[1]);
      deliver(rx_vec[4]);
      tick();
      check_eq("rxo_refill_count", 32'(rx_count), 32'd5);
      // Fourth byte lands on a full FIFO together with a pop.
      w = 32'h03F00D01;
      for (int b = 0; b < 4; b++) begin
         put_inbound     = 1'b1;
         payload_inbound = 8'(w >> (24 - 8 * b));
         pkt_out_ready   = (b == 3);
         tick();
      end
      put_inbound     = 1'b0;
      payload_inbound = 8'h00;
      pkt_out_ready   = 1'b0;
      check_eq("rxo_pp_error", 32'(rx_error), 32'd0);
      check_eq("rxo_pp_count", 32'(rx_count), 32'd6);
      check_eq("rxo_pp_head", pkt_out, rx_vec[2]);

      // ---------------- reset mid-SEND
      do_reset();
      pkt_in        = 32'h12345678;
      pkt_in_valid  = 1'b1;
      free_outbound = 1'b1;
      tick();
      pkt_in_valid = 1'b0;
      tick();
      check_eq("rms_b0", 32'(payload_outbound), 32'h12);
      tick();
      check_eq("rms_b1", 32'(payload_outbound), 32'h34);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rms_put", 32'(put_outbound), 32'd0);
      check_eq("rms_payload", 32'(payload_outbound), 32'd0);
      check_eq("rms_tx_count", 32'(tx_count), 32'd0);
      check_eq("rms_in_ready", 32'(pkt_in_ready), 32'd1);
      check_eq("rms_free_in", 32'(free_inbound), 32'd1);
      tick();
      reset_n = 1'b1;
      tick();
      check_eq("rms_no_resume", 32'(put_outbound), 32'd0);
      pkt_in       = 32'hCAFEF00D;
      pkt_in_valid = 1'b1;
      tick();
      pkt_in_valid = 1'b0;
      tick();
      expect_tx_word("rms_new", 32'hCAFEF00D);
      check_eq("rms_new_count", 32'(tx_count), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rms_empty_put", 32'(put_outbound), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
